// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uartTX between NUM_REQ byte producers. Arbitration is round robin
// with a packet lock, so a multi-byte message goes out without being
// interleaved with other requesters. A burst limit forces the lock to release
// after MAX_BURST bytes. A watchdog flags a transmitter whose busy output never
// rises after a send pulse.
//
// Handshake: a byte moves from requester i when req_valid[i] & req_ready[i]
// are both high at a rising clk edge. req_ready is a single-cycle one-hot
// pulse. It is raised only in IDLE while uart_busy is low. req_valid may be
// held or dropped freely, because it is only looked at in IDLE.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        asynchronous active-high reset
//   req_valid    per-requester byte available
//   req_data     byte of requester i on bits [8i+7:8i]
//   req_last     byte is the final byte of its message
//   req_ready    one-hot accept pulse (combinational, IDLE only)
//   uart_send    one-cycle start pulse to uartTX (decoded from registered state)
//   uart_data    registered byte to uartTX data_in
//   uart_busy    uartTX busy
//   grant_idx    requester currently or last served
//   locked       packet lock held by grant_idx
//   err_timeout  sticky ack-timeout flag, cleared only by reset
//   dbg_state    current FSM state (0 IDLE, 1 ISSUE, 2 WAIT_ACK, 3 WAIT_DONE)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int IDX_W       = 2,
    parameter int MAX_BURST   = 16,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   uart_send,
    output logic [7:0]             uart_data,
    input  logic                   uart_busy,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   locked,
    output logic                   err_timeout,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [8:0]  BURST_LIM = 9'(MAX_BURST);
    localparam logic [16:0] TMO_LIM   = 17'(ACK_TIMEOUT);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic             locked_q, locked_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       burst_q, burst_d;
    logic [15:0]      tmo_q, tmo_d;
    logic             err_q, err_d;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cand_idx;
    int               cand;
    logic             accept;
    logic [8:0]       burst_inc;
    logic [16:0]      tmo_inc;

    // Requester selection. Under lock only the owner is eligible. Otherwise
    // the first valid requester wins, searching from rr+1 upward with wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        if (locked_q) begin
            sel_found = req_valid[grant_q];
            sel_idx   = grant_q;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand     = (int'(rr_q) + k) % NUM_REQ;
                cand_idx = IDX_W'(cand);
                if (!sel_found && req_valid[cand_idx]) begin
                    sel_found = 1'b1;
                    sel_idx   = cand_idx;
                end
            end
        end
    end

    assign accept    = (state_q == IDLE) && !uart_busy && sel_found;
    assign burst_inc = {1'b0, burst_q} + 9'd1;
    assign tmo_inc   = {1'b0, tmo_q} + 17'd1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            locked_q <= 1'b0;
            data_q   <= 8'h00;
            burst_q  <= 8'h00;
            tmo_q    <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            locked_q <= locked_d;
            data_q   <= data_d;
            burst_q  <= burst_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        locked_d = locked_q;
        data_d   = data_q;
        burst_d  = burst_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                tmo_d = 16'h0000;
                if (accept) begin
                    data_d  = req_data[8*sel_idx +: 8];
                    grant_d = sel_idx;
                    state_d = ISSUE;
                    // The burst count includes every byte of the current lock,
                    // so the MAX_BURST-th byte releases it.
                    if (req_last[sel_idx] || (burst_inc >= BURST_LIM)) begin
                        locked_d = 1'b0;
                        burst_d  = 8'h00;
                        rr_d     = sel_idx;
                    end else begin
                        locked_d = 1'b1;
                        burst_d  = burst_inc[7:0];
                    end
                end
            end
            ISSUE: begin
                // The watchdog counts from the send cycle itself, so err_timeout
                // shows up ACK_TIMEOUT cycles after uart_send.
                tmo_d   = tmo_inc[15:0];
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (uart_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_inc >= TMO_LIM) begin
                    // The byte is dropped, not retried.
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    burst_d  = 8'h00;
                    rr_d     = grant_q;
                    tmo_d    = 16'h0000;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_inc[15:0];
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    assign uart_send   = (state_q == ISSUE);
    assign uart_data   = data_q;
    assign grant_idx   = grant_q;
    assign locked      = locked_q;
    assign err_timeout = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// Directed bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4, ACK_TIMEOUT=8).
// A negedge environment process plays the byte producers, which are fed from
// per-requester queues. It also plays a simple uartTX busy model, and it logs
// every accepted and every transmitted byte.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int IDX_W       = 2;
    localparam int MAX_BURST   = 4;
    localparam int ACK_TIMEOUT = 8;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]   req_last  = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_send;
    logic [7:0]           uart_data;
    logic                 uart_busy = 1'b0;
    logic [IDX_W-1:0]     grant_idx;
    logic                 locked;
    logic                 err_timeout;
    logic [1:0]           dbg_state;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .MAX_BURST(MAX_BURST), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .uart_send(uart_send), .uart_data(uart_data), .uart_busy(uart_busy),
        .grant_idx(grant_idx), .locked(locked), .err_timeout(err_timeout), .dbg_state(dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // producer queues: entry = {last, data}
    logic [8:0] pq [NUM_REQ][$];
    // scoreboard logs and expectations: entry = {idx, data}
    logic [9:0] acc_q[$];
    logic       lock_q[$];
    int         acc_cyc_q[$];
    logic [7:0] sent_q[$];
    int         send_cyc_q[$];
    logic [9:0] exp_q[$];
    logic       exp_lock_q[$];
    int         hot_viol = 0;
    int         busy_len = 3;
    bit         model_en = 1'b1;
    int         busy_cnt = 0;
    logic [8:0] env_e;

    // environment: busy model + producers + accept logger
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt  = 0;
            uart_busy = 1'b0;
        end else if (uart_send) begin
            sent_q.push_back(uart_data);
            send_cyc_q.push_back(cyc);
            if (model_en) begin
                uart_busy = 1'b1;
                busy_cnt  = busy_len;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) uart_busy = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            env_e = (pq[i].size() > 0) ? pq[i][0] : 9'h000;
            req_valid[i]       = (pq[i].size() > 0);
            req_data[8*i +: 8] = env_e[7:0];
            req_last[i]        = env_e[8];
        end
        #1;
        if ($countones(req_ready) > 1) hot_viol++;
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && req_valid[i] && pq[i].size() > 0) begin
                    env_e = pq[i][0];
                    acc_q.push_back({2'(i), env_e[7:0]});
                    lock_q.push_back(locked);
                    acc_cyc_q.push_back(cyc + 1);
                    void'(pq[i].pop_front());
                end
            end
        end
    end

    // driver tasks
    task automatic clear_logs();
        acc_q.delete(); lock_q.delete(); acc_cyc_q.delete();
        sent_q.delete(); send_cyc_q.delete();
        exp_q.delete(); exp_lock_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        clear_logs();
    endtask

    task automatic drain(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            #2;
            if (pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 && pq[3].size() == 0 &&
                req_valid == '0 && dbg_state == 2'd0 && !uart_busy && busy_cnt == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_cmp++; if (uart_send !== 1'b0) begin n_err++; $display("FAIL reset_send: got %b want 0", uart_send); end
        n_cmp++; if (uart_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", uart_data); end
        n_cmp++; if (grant_idx !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", grant_idx); end
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        do_reset();
    endtask

    task automatic test_single_byte();
        bit ok;
        clear_logs();
        pq[2].push_back({1'b1, 8'hA5});
        drain(200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL single_drain: got timeout want idle"); end
        n_cmp++;
        if (acc_q.size() != 1 || acc_q[0] !== {2'd2, 8'hA5}) begin
            n_err++; $display("FAIL single_accept: got %0d accepts, want 1 of req2/a5", acc_q.size());
        end
        n_cmp++;
        if (sent_q.size() != 1 || sent_q[0] !== 8'hA5) begin
            n_err++; $display("FAIL single_sent: got %0d sends, want 1 of a5", sent_q.size());
        end else begin
            n_cmp++;
            if (acc_cyc_q.size() != 1 || send_cyc_q[0] != acc_cyc_q[0]) begin
                n_err++; $display("FAIL single_latency: send cycle %0d, want cycle after accept", send_cyc_q[0]);
            end
        end
        n_cmp++; if (grant_idx !== 2'd2) begin n_err++; $display("FAIL single_grant: got %0d want 2", grant_idx); end
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL single_locked: got %b want 0", locked); end
        n_cmp++; if (hot_viol != 0) begin n_err++; $display("FAIL single_onehot: got %0d violations want 0", hot_viol); end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        pq[0].push_back({1'b1, 8'h10});
        pq[1].push_back({1'b1, 8'h11});
        pq[3].push_back({1'b1, 8'h13});
        exp_q = '{ {2'd1, 8'h11}, {2'd3, 8'h13}, {2'd0, 8'h10} };
        drain(300, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_drain: got timeout want idle"); end
        n_cmp++;
        if (acc_q.size() != exp_q.size() || sent_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rr_count: got %0d/%0d want %0d", acc_q.size(), sent_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (acc_q[i] !== exp_q[i] || sent_q[i] !== exp_q[i][7:0]) begin
                    n_err++; $display("FAIL rr_order[%0d]: got %h sent %h want %h", i, acc_q[i], sent_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_packet_lock();
        bit ok;
        clear_logs();
        pq[3].push_back({1'b1, 8'h33});   // moves the rr pointer to 3
        drain(200, ok);
        clear_logs();
        pq[0].push_back({1'b0, 8'h01});
        pq[0].push_back({1'b0, 8'h02});
        pq[0].push_back({1'b1, 8'h03});
        pq[1].push_back({1'b1, 8'h21});
        exp_q      = '{ {2'd0, 8'h01}, {2'd0, 8'h02}, {2'd0, 8'h03}, {2'd1, 8'h21} };
        exp_lock_q = '{ 1'b0, 1'b1, 1'b1, 1'b0 };
        drain(400, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL lock_drain: got timeout want idle"); end
        n_cmp++;
        if (acc_q.size() != exp_q.size() || sent_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL lock_count: got %0d/%0d want %0d", acc_q.size(), sent_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (acc_q[i] !== exp_q[i] || sent_q[i] !== exp_q[i][7:0] || lock_q[i] !== exp_lock_q[i]) begin
                    n_err++; $display("FAIL lock_order[%0d]: got %h lock %b want %h lock %b",
                                      i, acc_q[i], lock_q[i], exp_q[i], exp_lock_q[i]);
                end
            end
        end
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL lock_release: got %b want 0", locked); end
    endtask

    task automatic test_burst_limit();
        bit ok;
        int n_before;
        clear_logs();
        for (int b = 0; b < 6; b++) pq[2].push_back({1'b0, 8'h40 + 8'(b)});
        pq[3].push_back({1'b1, 8'h50});
        exp_q      = '{ {2'd2, 8'h40}, {2'd2, 8'h41}, {2'd2, 8'h42}, {2'd2, 8'h43},
                        {2'd3, 8'h50}, {2'd2, 8'h44}, {2'd2, 8'h45} };
        exp_lock_q = '{ 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1 };
        drain(600, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL burst_drain: got timeout want idle"); end
        n_cmp++;
        if (acc_q.size() != exp_q.size() || sent_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL burst_count: got %0d/%0d want %0d", acc_q.size(), sent_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (acc_q[i] !== exp_q[i] || sent_q[i] !== exp_q[i][7:0] || lock_q[i] !== exp_lock_q[i]) begin
                    n_err++; $display("FAIL burst_order[%0d]: got %h lock %b want %h lock %b",
                                      i, acc_q[i], lock_q[i], exp_q[i], exp_lock_q[i]);
                end
            end
        end
        n_cmp++; if (locked !== 1'b1 || grant_idx !== 2'd2) begin
            n_err++; $display("FAIL burst_held: got lock %b grant %0d want lock 1 grant 2", locked, grant_idx);
        end
        // The lock holder has nothing to send, and other requesters stay blocked.
        n_before = acc_q.size();
        pq[0].push_back({1'b1, 8'h60});
        repeat (30) @(negedge clk);
        n_cmp++; if (acc_q.size() != n_before) begin
            n_err++; $display("FAIL lock_hold: got %0d accepts want %0d", acc_q.size(), n_before);
        end
    endtask

    task automatic test_ack_timeout();
        bit ok;
        bit seen;
        int s;
        do_reset();
        model_en = 1'b0;
        seen = 1'b0;
        s = 0;
        pq[1].push_back({1'b1, 8'h55});
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #3;
            if (uart_send) begin seen = 1'b1; s = cyc; break; end
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL tmo_send: got no uart_send want one"); end
        repeat (ACK_TIMEOUT - 1) @(negedge clk);
        #3;
        n_cmp++; if (err_timeout !== 1'b0) begin
            n_err++; $display("FAIL tmo_early: got err %b at send+%0d want 0", err_timeout, cyc - s);
        end
        @(negedge clk);
        #3;
        n_cmp++; if (err_timeout !== 1'b1) begin
            n_err++; $display("FAIL tmo_flag: got err %b at send+%0d want 1", err_timeout, cyc - s);
        end
        n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL tmo_state: got %0d want 0", dbg_state); end
        model_en = 1'b1;
        pq[2].push_back({1'b1, 8'h66});
        exp_q = '{ {2'd1, 8'h55}, {2'd2, 8'h66} };
        drain(200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL tmo_drain: got timeout want idle"); end
        n_cmp++;
        if (acc_q.size() != 2 || sent_q.size() != 2 || acc_q[1] !== exp_q[1] || sent_q[1] !== 8'h66) begin
            n_err++; $display("FAIL tmo_next: got %0d accepts %0d sends want req2/66 served", acc_q.size(), sent_q.size());
        end
        n_cmp++; if (err_timeout !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b want 1", err_timeout); end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        bit hit;
        do_reset();
        busy_len = 20;
        hit = 1'b0;
        pq[0].push_back({1'b0, 8'h81});
        pq[0].push_back({1'b0, 8'h82});
        pq[0].push_back({1'b1, 8'h83});
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #3;
            if (dbg_state == 2'd3 && locked) begin hit = 1'b1; break; end
        end
        n_cmp++; if (!hit) begin n_err++; $display("FAIL rst_reach: got no locked WAIT_DONE want one"); end
        #1 reset = 1'b1;
        #0.5;
        n_cmp++;
        if (req_ready !== 4'b0 || uart_send !== 1'b0 || uart_data !== 8'h00 || grant_idx !== 2'd0 ||
            locked !== 1'b0 || err_timeout !== 1'b0 || dbg_state !== 2'd0) begin
            n_err++; $display("FAIL rst_async: got ready %b send %b data %h grant %0d lock %b err %b st %0d want all 0",
                              req_ready, uart_send, uart_data, grant_idx, locked, err_timeout, dbg_state);
        end
        for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        busy_len = 3;
        clear_logs();
        pq[0].push_back({1'b1, 8'h70});
        pq[1].push_back({1'b1, 8'h71});
        pq[3].push_back({1'b1, 8'h73});
        exp_q = '{ {2'd1, 8'h71}, {2'd3, 8'h73}, {2'd0, 8'h70} };
        drain(300, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_drain: got timeout want idle"); end
        n_cmp++;
        if (acc_q.size() != 3 || acc_q[0] !== exp_q[0] || acc_q[1] !== exp_q[1] || acc_q[2] !== exp_q[2]) begin
            n_err++; $display("FAIL rst_restart: got %0d accepts first %h want 3 starting %h", acc_q.size(), acc_q[0], exp_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_burst_limit();
        test_ack_timeout();
        test_reset_mid_packet();
        n_cmp++; if (hot_viol != 0) begin n_err++; $display("FAIL onehot_total: got %0d violations want 0", hot_viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uartTX instance between NUM_REQ byte producers (console, debug and status engines).
- Round-robin arbitration with packet lock, so multi-byte messages are not interleaved.
- Drives the transmitter's send/data_in pair and sequences each byte off its busy output.
- Includes a burst limit for fairness and a watchdog that detects a transmitter that never acknowledges.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, 2, width of grant index; must be >= clog2(NUM_REQ)
MAX_BURST, 16, max bytes one requester may send under lock before forced release (1..255)
ACK_TIMEOUT, 64, cycles to wait for uart_busy to rise after uart_send before flagging error (2..65535)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  8*NUM_REQ  byte for requester i on bits [8i+7:8i]
req_last  in  NUM_REQ  byte is final byte of its message
req_ready  out  NUM_REQ  one-hot pulse; byte accepted when req_valid[i] & req_ready[i]
uart_send  out  1  one-cycle start pulse to uartTX send
uart_data  out  8  byte to uartTX data_in
uart_busy  in  1  uartTX busy
grant_idx  out  IDX_W  index of requester currently or last served
locked  out  1  packet lock held by grant_idx
err_timeout  out  1  sticky; set on ack timeout, cleared only by reset

Behaviour:
- Reset values:
  - outputs: req_ready=0, uart_send=0, uart_data=8'h00, grant_idx=0, locked=0, err_timeout=0.
  - internal: state=IDLE, rr pointer=0, burst count=0, timeout counter=0.
  - Reset mid-byte simply abandons the sequence; uart_send drops asynchronously.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE arbitration (only when uart_busy=0):
  - If locked=1: only requester grant_idx is eligible. If its req_valid=0, wait in IDLE; the lock is held indefinitely and no other requester is served.
  - If locked=0: choose the first i with req_valid[i]=1, searching (rr+1) mod NUM_REQ upward with wrap. rr=0 after reset, so requester 1 has first priority, then 2, 3, 0.
  - On selection: combinationally assert req_ready[i] that cycle. Register uart_data<=byte, grant_idx<=i, then go to ISSUE.
  - At most one req_ready bit high in any cycle; req_ready is never high outside IDLE.
- ISSUE: uart_send=1 for exactly this one cycle; go to WAIT_ACK. Accept at cycle T gives uart_send high at T+1. uart_data stays stable from T+1 until the next accept.
- WAIT_ACK:
  - When uart_busy=1, go to WAIT_DONE.
  - Timeout counter increments each cycle; on reaching ACK_TIMEOUT: set err_timeout, clear locked, rr<=grant_idx, go to IDLE. The byte is dropped, not retried.
- WAIT_DONE: when uart_busy=0, go to IDLE. Back-to-back bytes therefore start no earlier than the cycle after busy falls.
- Lock and burst update, registered with the accept:
  - burst count increments per accepted byte while locked.
  - If req_last=1: locked<=0, burst<=0, rr<=i.
  - Else if burst count reaches MAX_BURST: forced release with locked<=0, burst<=0, rr<=i.
  - Else: locked<=1.
  - A released requester competes normally in the next round.
- Simultaneous events:
  - A req_valid change while not in IDLE is ignored until IDLE.
  - uart_busy already high on entry to IDLE blocks arbitration.
  - req_valid is sampled only in IDLE.
- No combinational path from req_valid to uart_send; uart_send and uart_data are registered.

Test Plan:
- Single byte: req_valid[2]=1, data 8'hA5, last=1 → req_ready[2] pulses 1 cycle, uart_send high the next cycle with uart_data=8'hA5, grant_idx=2, locked stays 0, line carries start+A5+stop.
- Round robin: after reset, all of req 0, 1, 3 valid with last=1, data 8'h10/8'h11/8'h13 → serve order 1, 3, 0; serial bytes 8'h11, 8'h13, 8'h10.
- Packet lock: req 0 sends 3 bytes 8'h01, 8'h02, 8'h03 (last on third) while req 1 valid throughout → locked=1 after the first byte; req 1 is served only after 8'h03.
- Burst limit (MAX_BURST=4): req 2 streams 6 bytes with last=0 while req 3 valid → after 4 bytes locked=0, req 3 gets the next slot, then req 2 resumes.
- Ack timeout (ACK_TIMEOUT=8): uart_busy tied 0 and req 1 sends 8'h55 → err_timeout=1 exactly 8 cycles after uart_send, state returns to IDLE, the next request is still served.
- Reset mid-packet: assert reset in WAIT_DONE while locked=1 → all outputs reach reset values asynchronously; after release, arbitration restarts at requester 1.
